// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared types and defaults for the DDS tone/sweep controller.
package dds_sweep_ctrl_pkg;

    localparam int unsigned DEF_ACC_W    = 32;
    localparam int unsigned DEF_CORE_LAT = 18;
    localparam int unsigned ANGLE_W      = 20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TONE,
        ST_SWEEP,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/dds_vld_dly.sv
// Valid-bit delay line matching the sin/cos core latency.
module dds_vld_dly #(
    parameter int unsigned LAT = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_vld,
    output logic delayed_vld,
    output logic any_valid
);

    logic [LAT-1:0] sr;
    logic [LAT-1:0] sr_nxt;

    generate
        if (LAT == 1) begin : g_single
            assign sr_nxt = sample_vld;
        end else begin : g_multi
            assign sr_nxt = {sr[LAT-2:0], sample_vld};
        end
    endgenerate

    // Shift the valid bit along the line; cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= sr_nxt;
        end
    end

    assign delayed_vld = sr[LAT-1];
    // Looks at the line as it will be after this edge, so the last valid bit
    // leaving the output stage already reads as empty.
    assign any_valid   = |sr_nxt;

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Phase accumulator and tone/linear-sweep sequencer feeding a sin/cos core.
module dds_sweep_ctrl
    import dds_sweep_ctrl_pkg::*;
#(
    parameter int unsigned CORE_LAT = DEF_CORE_LAT,
    parameter int unsigned ACC_W    = DEF_ACC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic               cfg_mode,
    input  logic [ACC_W-1:0]   cfg_ftw,
    input  logic [ACC_W-1:0]   cfg_step,
    input  logic [15:0]        cfg_seg_num,
    input  logic [15:0]        cfg_dwell,
    input  logic [ANGLE_W-1:0] cfg_phase_off,
    input  logic               start,
    input  logic               stop,
    output logic [ANGLE_W-1:0] angle_o,
    output logic               angle_vld_o,
    output logic               out_vld_o,
    output logic               busy_o,
    output logic               done_o
);

    state_t             state;

    logic               sh_mode;
    logic [ACC_W-1:0]   sh_ftw;
    logic [ACC_W-1:0]   sh_step;
    logic [15:0]        sh_seg_num;
    logic [15:0]        sh_dwell;
    logic [ANGLE_W-1:0] sh_phase_off;

    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   ftw;
    logic [15:0]        seg_cnt;
    logic [15:0]        dwell_cnt;

    logic [ACC_W-1:0]   acc_sum;
    logic [ANGLE_W-1:0] angle_nxt;
    logic               last_dwell;
    logic               last_seg;
    logic               any_valid;

    // acc holds the phase shown in the current valid cycle; the next angle
    // is derived from the advanced value so angle_o stays registered.
    assign acc_sum    = acc + ftw;
    assign angle_nxt  = acc_sum[ACC_W-1 -: ANGLE_W] + sh_phase_off;
    assign last_dwell = (dwell_cnt == sh_dwell);
    assign last_seg   = (seg_cnt == sh_seg_num);

    assign cfg_ready  = (state == ST_IDLE);
    assign busy_o     = (state != ST_IDLE);

    // Main sequencer: config capture, tone/sweep generation and drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            sh_mode      <= 1'b0;
            sh_ftw       <= '0;
            sh_step      <= '0;
            sh_seg_num   <= '0;
            sh_dwell     <= '0;
            sh_phase_off <= '0;
            acc          <= '0;
            ftw          <= '0;
            seg_cnt      <= '0;
            dwell_cnt    <= '0;
            angle_o      <= '0;
            angle_vld_o  <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        sh_mode      <= cfg_mode;
                        sh_ftw       <= cfg_ftw;
                        sh_step      <= cfg_step;
                        sh_seg_num   <= cfg_seg_num;
                        sh_dwell     <= cfg_dwell;
                        sh_phase_off <= cfg_phase_off;
                    end else if (start) begin
                        acc         <= '0;
                        ftw         <= sh_ftw;
                        seg_cnt     <= '0;
                        dwell_cnt   <= '0;
                        angle_o     <= sh_phase_off;
                        angle_vld_o <= 1'b1;
                        state       <= sh_mode ? ST_SWEEP : ST_TONE;
                    end
                end
                ST_TONE: begin
                    if (stop) begin
                        angle_vld_o <= 1'b0;
                        state       <= ST_DRAIN;
                    end else begin
                        acc     <= acc_sum;
                        angle_o <= angle_nxt;
                    end
                end
                ST_SWEEP: begin
                    if (stop || (last_dwell && last_seg)) begin
                        angle_vld_o <= 1'b0;
                        state       <= ST_DRAIN;
                    end else begin
                        acc     <= acc_sum;
                        angle_o <= angle_nxt;
                        if (last_dwell) begin
                            dwell_cnt <= '0;
                            seg_cnt   <= seg_cnt + 16'd1;
                            ftw       <= ftw + sh_step;
                        end else begin
                            dwell_cnt <= dwell_cnt + 16'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!any_valid) begin
                        done_o <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    dds_vld_dly #(
        .LAT (CORE_LAT)
    ) u_vld_dly (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_vld  (angle_vld_o),
        .delayed_vld (out_vld_o),
        .any_valid   (any_valid)
    );

endmodule
